medidor_sequenciador_uc: RTL

MEDIDOR_SEQUENCIADOR_UC -- requirements
Module: medidor_sequenciador_uc

---
 rtl/medidor_sequenciador_uc.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/medidor_sequenciador_uc.sv
// Control unit that sequences one ultrasonic distance measurement:
// clear datapath, send trigger pulse, wait for echo, wait for the datapath's
// done flag, store the result, then report done or timeout.
//
// Build option: define MEDIDA_CONTINUA_EN to repeat measurements
// automatically, INTERVALO_CYCLES apart. Without it every measurement needs medir.
//
// Ports
//   clock         : single clock, rising edge
//   reset         : asynchronous, active-low
//   medir         : start request, honoured only in INICIAL
//   echo          : sensor echo, already synchronized
//   pronto_medida : one-cycle done flag from the cm-counting datapath
//   trigger       : sensor trigger pin
//   zera          : clears datapath counters and distance register
//   registra      : loads the datapath result into the distance register
//   pronto        : one-cycle measurement-complete pulse
//   timeout_err   : one-cycle timed-out-measurement flag
//   db_estado     : current state code, for debug
module medidor_sequenciador_uc #(
  parameter int unsigned TRIGGER_CYCLES   = 500,
  parameter int unsigned TIMEOUT_CYCLES   = 1500000,
  parameter int unsigned INTERVALO_CYCLES = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       medir,
  input  logic       echo,
  input  logic       pronto_medida,
  output logic       trigger,
  output logic       zera,
  output logic       registra,
  output logic       pronto,
  output logic       timeout_err,
  output logic [3:0] db_estado
);

  localparam int unsigned MAX_CYCLES = (TIMEOUT_CYCLES > INTERVALO_CYCLES) ?
                                       TIMEOUT_CYCLES : INTERVALO_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] S_INICIAL       = 4'd0;
  localparam logic [3:0] S_PREPARA       = 4'd1;
  localparam logic [3:0] S_ENVIA_TRIGGER = 4'd2;
  localparam logic [3:0] S_ESPERA_ECHO   = 4'd3;
  localparam logic [3:0] S_MEDIDA        = 4'd4;
  localparam logic [3:0] S_ARMAZENA      = 4'd5;
  localparam logic [3:0] S_FINAL         = 4'd6;
  localparam logic [3:0] S_ERRO          = 4'd7;
`ifdef MEDIDA_CONTINUA_EN
  localparam logic [3:0] S_INTERVALO     = 4'd8;
  localparam logic [3:0] S_POS_MEDIDA    = S_INTERVALO;
`else
  localparam logic [3:0] S_POS_MEDIDA    = S_INICIAL;
`endif

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trigger_q, trigger_d;
  logic             zera_q, zera_d;
  logic             registra_q, registra_d;
  logic             pronto_q, pronto_d;
  logic             timeout_err_q, timeout_err_d;

  // Terminal counts: counter starts at 0 on state entry, so N cycles end at N-1
  logic tc_trigger, tc_timeout;
  assign tc_trigger = (cnt_q == CNT_W'(TRIGGER_CYCLES - 1));
  assign tc_timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`ifdef MEDIDA_CONTINUA_EN
  logic tc_intervalo;
  assign tc_intervalo = (cnt_q == CNT_W'(INTERVALO_CYCLES - 1));
`endif

  // Next-state, counter and output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    trigger_d     = 1'b0;
    zera_d        = 1'b0;
    registra_d    = 1'b0;
    pronto_d      = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      S_INICIAL:       if (medir) state_d = S_PREPARA;
      S_PREPARA:       state_d = S_ENVIA_TRIGGER;
      S_ENVIA_TRIGGER: if (tc_trigger) state_d = S_ESPERA_ECHO;
      S_ESPERA_ECHO: begin
        if (echo)            state_d = S_MEDIDA;
        else if (tc_timeout) state_d = S_ERRO;
      end
      // A done flag on the timeout cycle still counts as a good measurement
      S_MEDIDA: begin
        if (pronto_medida)   state_d = S_ARMAZENA;
        else if (tc_timeout) state_d = S_ERRO;
      end
      S_ARMAZENA:      state_d = S_FINAL;
      S_FINAL, S_ERRO: state_d = S_POS_MEDIDA;
`ifdef MEDIDA_CONTINUA_EN
      S_INTERVALO:     if (tc_intervalo) state_d = S_PREPARA;
`endif
      default:         state_d = S_INICIAL;
    endcase

    // Counter restarts on every state change and saturates instead of wrapping
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);

    // Moore outputs decoded from the next state so they register with it
    trigger_d     = (state_d == S_ENVIA_TRIGGER);
    zera_d        = (state_d == S_PREPARA) || (state_d == S_ERRO);
    registra_d    = (state_d == S_ARMAZENA);
    pronto_d      = (state_d == S_FINAL);
    timeout_err_d = (state_d == S_ERRO);
  end

  // State, counter and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_INICIAL;
      cnt_q         <= '0;
      trigger_q     <= 1'b0;
      zera_q        <= 1'b0;
      registra_q    <= 1'b0;
      pronto_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      trigger_q     <= trigger_d;
      zera_q        <= zera_d;
      registra_q    <= registra_d;
      pronto_q      <= pronto_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign trigger     = trigger_q;
  assign zera        = zera_q;
  assign registra    = registra_q;
  assign pronto      = pronto_q;
  assign timeout_err = timeout_err_q;
  assign db_estado   = state_q;

endmodule
